// File: rtl/cpu_io_pkg.sv
// ============================================================================
// Module      : cpu_io_pkg
// Description : Shared definitions for the CPU I/O stream bridge: per-channel
//               mode encodings and a constant-foldable ceil(log2) helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_io_pkg;

  // Per-channel mode encoding (two ConfigMem bits per channel)
  localparam logic [1:0] MODE_PASS = 2'b00;  // combinational pass-through
  localparam logic [1:0] MODE_REG  = 2'b01;  // single UserCLK flop
  localparam logic [1:0] MODE_FIFO = 2'b10;  // elastic FIFO
  localparam logic [1:0] MODE_HOLD = 2'b11;  // FIFO, output holds last dequeued value

  // ceil(log2(value)); returns 0 for value <= 1
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Both FIFO modes share the MSB of the encoding
  function automatic logic is_fifo_mode(input logic [1:0] mode);
    return mode[1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/io_chan_fifo.sv
// ============================================================================
// Module      : io_chan_fifo
// Description : Single-channel elastic FIFO with registered count, no
//               fall-through, synchronous flush and an optional hold register
//               that presents the last dequeued value while empty.
// Ports       : clk, rst_n        - clock, asynchronous active-low reset
//               flush             - clear pointers, count and hold register
//               wr_en / wr_data   - enqueue request (dropped when full unless
//                                   a read happens the same cycle)
//               rd_en / rd_data   - dequeue request (ignored when empty), head
//               empty / full      - occupancy flags
//               hold_en           - present hold register instead of stale head
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_chan_fifo
  import cpu_io_pkg::*;
#(
  parameter int DataWidth = 4,
  parameter int FifoDepth = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 wr_en,
  input  logic [DataWidth-1:0] wr_data,
  input  logic                 rd_en,
  output logic [DataWidth-1:0] rd_data,
  output logic                 empty,
  output logic                 full,
  input  logic                 hold_en
);

  localparam int PTR_W = (FifoDepth > 1) ? clog2(FifoDepth) : 1;
  localparam int CNT_W = clog2(FifoDepth + 1);

  logic [DataWidth-1:0] r_mem [FifoDepth];
  logic [PTR_W-1:0]     r_wptr;
  logic [PTR_W-1:0]     r_rptr;
  logic [CNT_W-1:0]     r_count;
  logic [DataWidth-1:0] r_hold;

  logic                 w_do_rd;
  logic                 w_do_wr;

  assign empty   = (r_count == '0);
  assign full    = (r_count == CNT_W'(FifoDepth));
  assign w_do_rd = rd_en & ~empty;
  // A write into a full FIFO is still accepted when the head leaves this cycle
  assign w_do_wr = wr_en & (~full | w_do_rd);

  assign rd_data = (hold_en & empty) ? r_hold : r_mem[r_rptr];

  // Storage carries no reset; validity is tracked by the count alone
  always_ff @(posedge clk) begin
    if (w_do_wr & ~flush) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because FifoDepth is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_hold  <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_hold  <= '0;
    end else begin
      if (w_do_wr) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_do_rd) begin
        r_rptr <= r_rptr + PTR_W'(1);
        r_hold <= r_mem[r_rptr];
      end
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu_io_stream_bridge.sv
// ============================================================================
// Module      : cpu_io_stream_bridge
// Description : Parametrised CPU <-> fabric I/O bridge. NumOp operand channels
//               (CPU -> fabric) and NumRes result channels (fabric -> CPU),
//               each independently configured as PASS, REG, FIFO or FIFO_HOLD.
// Ports       : UserCLK, UserRSTn        - user clock, async active-low reset
//               ConfigBits               - 2 mode bits/channel, operands first
//               OP_I/OP_valid/OP_ready   - CPU operand side
//               OP_O/OP_avail/OP_pop     - fabric operand side
//               RES_I/RES_push/RES_full  - fabric result side
//               RES_O/RES_valid/RES_ready- CPU result side
//               RES_ovf                  - sticky per-channel overflow flags
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_io_stream_bridge
  import cpu_io_pkg::*;
#(
  parameter  int NumOp        = 2,
  parameter  int NumRes       = 3,
  parameter  int DataWidth    = 4,
  parameter  int FifoDepth    = 4,
  localparam int NoConfigBits = 2 * (NumOp + NumRes)
) (
  input  logic                        UserCLK,
  input  logic                        UserRSTn,
  input  logic [NoConfigBits-1:0]     ConfigBits,
  input  logic [NumOp*DataWidth-1:0]  OP_I,
  input  logic [NumOp-1:0]            OP_valid,
  output logic [NumOp-1:0]            OP_ready,
  output logic [NumOp*DataWidth-1:0]  OP_O,
  output logic [NumOp-1:0]            OP_avail,
  input  logic [NumOp-1:0]            OP_pop,
  input  logic [NumRes*DataWidth-1:0] RES_I,
  input  logic [NumRes-1:0]           RES_push,
  output logic [NumRes-1:0]           RES_full,
  output logic [NumRes*DataWidth-1:0] RES_O,
  output logic [NumRes-1:0]           RES_valid,
  input  logic [NumRes-1:0]           RES_ready,
  output logic [NumRes-1:0]           RES_ovf
);

  // --------------------------------------------------------------------------
  // Operand channels: CPU -> fabric
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NumOp; k++) begin : g_op
    logic [1:0]           w_mode;
    logic [1:0]           r_mode;
    logic                 w_is_fifo;
    logic                 w_flush;
    logic                 w_full;
    logic                 w_empty;
    logic [DataWidth-1:0] w_in;
    logic [DataWidth-1:0] r_reg;
    logic [DataWidth-1:0] w_fifo_data;
    logic [DataWidth-1:0] w_out;
    logic                 w_ready;
    logic                 w_avail;

    assign w_mode    = ConfigBits[2*k +: 2];
    assign w_in      = OP_I[k*DataWidth +: DataWidth];
    assign w_is_fifo = is_fifo_mode(w_mode);
    // Clear on a live mode change; non-FIFO modes keep the queue empty
    assign w_flush   = (r_mode != w_mode) | ~w_is_fifo;

    always_ff @(posedge UserCLK or negedge UserRSTn) begin
      if (!UserRSTn) begin
        r_mode <= '0;
        r_reg  <= '0;
      end else begin
        r_mode <= w_mode;
        r_reg  <= w_in;
      end
    end

    io_chan_fifo #(
      .DataWidth (DataWidth),
      .FifoDepth (FifoDepth)
    ) u_fifo (
      .clk     (UserCLK),
      .rst_n   (UserRSTn),
      .flush   (w_flush),
      // Operand writes require OP_ready, so no write-while-full-with-pop here
      .wr_en   (w_is_fifo & OP_valid[k] & ~w_full),
      .wr_data (w_in),
      .rd_en   (w_is_fifo & OP_pop[k]),
      .rd_data (w_fifo_data),
      .empty   (w_empty),
      .full    (w_full),
      .hold_en (w_mode == MODE_HOLD)
    );

    always_comb begin
      w_out   = w_fifo_data;
      w_ready = ~w_full;
      w_avail = ~w_empty;
      case (w_mode)
        MODE_PASS: begin
          w_out   = w_in;
          w_ready = 1'b1;
          w_avail = 1'b1;
        end
        MODE_REG: begin
          w_out   = r_reg;
          w_ready = 1'b1;
          w_avail = 1'b1;
        end
        default: ;
      endcase
    end

    assign OP_O[k*DataWidth +: DataWidth] = w_out;
    assign OP_ready[k]                    = w_ready;
    assign OP_avail[k]                    = w_avail;
  end

  // --------------------------------------------------------------------------
  // Result channels: fabric -> CPU
  // --------------------------------------------------------------------------
  for (genvar j = 0; j < NumRes; j++) begin : g_res
    logic [1:0]           w_mode;
    logic [1:0]           r_mode;
    logic                 w_is_fifo;
    logic                 w_changed;
    logic                 w_flush;
    logic                 w_full;
    logic                 w_empty;
    logic [DataWidth-1:0] w_in;
    logic [DataWidth-1:0] r_reg;
    logic [DataWidth-1:0] w_fifo_data;
    logic [DataWidth-1:0] w_out;
    logic                 w_valid;
    logic                 w_full_out;
    logic                 w_drop;
    logic                 r_ovf;

    assign w_mode    = ConfigBits[2*(NumOp+j) +: 2];
    assign w_in      = RES_I[j*DataWidth +: DataWidth];
    assign w_is_fifo = is_fifo_mode(w_mode);
    assign w_changed = (r_mode != w_mode);
    assign w_flush   = w_changed | ~w_is_fifo;
    // Entry is lost only when full and the CPU does not free a slot this cycle
    assign w_drop    = w_is_fifo & RES_push[j] & w_full & ~(RES_ready[j] & ~w_empty);

    always_ff @(posedge UserCLK or negedge UserRSTn) begin
      if (!UserRSTn) begin
        r_mode <= '0;
        r_reg  <= '0;
        r_ovf  <= 1'b0;
      end else begin
        r_mode <= w_mode;
        r_reg  <= w_in;
        if (w_changed) begin
          r_ovf <= 1'b0;
        end else if (w_drop) begin
          r_ovf <= 1'b1;
        end
      end
    end

    io_chan_fifo #(
      .DataWidth (DataWidth),
      .FifoDepth (FifoDepth)
    ) u_fifo (
      .clk     (UserCLK),
      .rst_n   (UserRSTn),
      .flush   (w_flush),
      .wr_en   (w_is_fifo & RES_push[j]),
      .wr_data (w_in),
      .rd_en   (w_is_fifo & RES_ready[j]),
      .rd_data (w_fifo_data),
      .empty   (w_empty),
      .full    (w_full),
      .hold_en (w_mode == MODE_HOLD)
    );

    always_comb begin
      w_out      = w_fifo_data;
      w_valid    = ~w_empty;
      w_full_out = w_full;
      case (w_mode)
        MODE_PASS: begin
          w_out      = w_in;
          w_valid    = 1'b1;
          w_full_out = 1'b0;
        end
        MODE_REG: begin
          w_out      = r_reg;
          w_valid    = 1'b1;
          w_full_out = 1'b0;
        end
        default: ;
      endcase
    end

    assign RES_O[j*DataWidth +: DataWidth] = w_out;
    assign RES_valid[j]                    = w_valid;
    assign RES_full[j]                     = w_full_out;
    assign RES_ovf[j]                      = r_ovf;
  end

endmodule

`default_nettype wire

// File: doc/cpu_io_stream_bridge.md
Name: cpu_io_stream_bridge

Overview:
- Parametrised successor to the fixed 4-bit CPU interface tile BELs (InPass4/OutPass4).
- Bridges NumOp operand channels (CPU -> fabric) and NumRes result channels (fabric -> CPU), each DataWidth bits wide.
- Each channel has a per-channel configurable mode: combinational pass, single register, or elastic FIFO with a valid/ready handshake.
- Sits between the tile switch matrix and the tile top-level CPU pins. Mode bits come from the tile ConfigMem.

Parameters:
- NumOp, 2, number of operand channels (CPU -> fabric).
- NumRes, 3, number of result channels (fabric -> CPU).
- DataWidth, 4, bits per channel; must be >= 1.
- FifoDepth, 4, entries per channel FIFO; power of two, >= 2.
- NoConfigBits, 2*(NumOp+NumRes), width of the mode-bit bus; derived, not to be overridden.

Ports:
- UserCLK  in  1  user clock, shared with all tile BELs.
- UserRSTn  in  1  reset; asynchronous, active-low.
- ConfigBits  in  NoConfigBits  2 mode bits per channel; operand channels first (ch0 at [1:0]), then result channels.
- OP_I  in  NumOp*DataWidth  CPU operand data; channel k at [k*DataWidth +: DataWidth].
- OP_valid  in  NumOp  CPU operand valid.
- OP_ready  out  NumOp  operand accepted this cycle.
- OP_O  out  NumOp*DataWidth  operand data to the switch matrix.
- OP_avail  out  NumOp  operand channel has data (FIFO not empty).
- OP_pop  in  NumOp  fabric consumes the head entry.
- RES_I  in  NumRes*DataWidth  result data from the switch matrix.
- RES_push  in  NumRes  fabric enqueue strobe.
- RES_full  out  NumRes  result FIFO full, fed back to the fabric.
- RES_O  out  NumRes*DataWidth  result data to the CPU.
- RES_valid  out  NumRes  result available to the CPU.
- RES_ready  in  NumRes  CPU accepts the result.
- RES_ovf  out  NumRes  sticky overflow flag (push while full, entry dropped).

Behaviour:
Mode encoding per channel:
- 00 PASS: output = input, combinational; valid/ready/avail tied to 1; FIFO held empty.
- 01 REG: output is one UserCLK flop of input; valid/ready/avail = 1; latency 1.
- 10 FIFO: elastic FIFO with FifoDepth entries; head read combinationally from storage.
- 11 FIFO_HOLD: same as FIFO, but when empty the output keeps the last dequeued value instead of the stale head.

FIFO write and read rules:
- Operand write: OP_valid & OP_ready. OP_ready = !full.
- Result write: RES_push, accepted if !full, or if full with a same-cycle RES_ready & RES_valid.
- Operand read: OP_pop & !empty.
- Result read: RES_ready & RES_valid. RES_valid = !empty. OP_avail = !empty. RES_full = full.
- Write-to-output latency is 1 cycle. There is no fall-through: a push into an empty FIFO with a same-cycle pop leaves the count at 1.
- Count width is clog2(FifoDepth+1). Read and write pointers wrap modulo FifoDepth.

Boundary conditions:
- Pop on empty: ignored, no pointer change.
- Push on full with no pop (results): data dropped, RES_ovf[k] set. It stays set until reset or until a mode change on that channel.
- Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged, both pointers advance.
- Mode change: ConfigBits are registered per channel each cycle. When a channel's registered mode differs from the live bits, that channel's pointers, count and ovf flag are cleared on that edge, and its hold register is zeroed.

Reset (UserRSTn low, asynchronous):
- All pointers, counts, REG flops, hold registers, ovf flags and registered mode copies go to 0.
- RES_valid=0, OP_avail=0 in FIFO modes.
- OP_ready=1 and RES_full=0 in FIFO modes.
- PASS channels keep following their inputs.
- Reset mid-transfer discards all queued entries. The first write after deassertion goes to slot 0.

Decomposition:
- Package cpu_io_pkg: mode constants MODE_PASS/REG/FIFO/HOLD (2-bit) and a clog2 function.
- Sub-module io_chan_fifo (params DataWidth, FifoDepth): ports wr_en, wr_data, rd_en, rd_data, empty, full, flush, hold_en.
- Instantiate io_chan_fifo per channel with a generate loop, for both operand and result channels. The top level handles mode muxing, ovf flags and config-change flush.

Test Plan:
- Reset, then all channels FIFO (ConfigBits=all 10) -> OP_ready=all 1, OP_avail=0, RES_valid=0, RES_full=0, RES_ovf=0.
- Op ch0 FIFO: push 0x3,0x5,0x9,0xC on 4 cycles -> OP_ready[0]=0 after the 4th; pop 4 times -> OP_O[3:0]=3,5,9,C in order; OP_avail[0]=0 after the last pop; a 5th pop is ignored.
- Res ch1 full (4 entries); 5th RES_push with RES_ready=0 -> RES_ovf[1]=1, 0xF dropped. A push with same-cycle RES_ready=1 -> accepted, no ovf, count stays 4.
- Res ch2 mode 11: push 0xA, CPU reads it -> RES_O stays 0xA while RES_valid=0. Same sequence in mode 10 -> RES_valid=0 and RES_O is don't-care.
- Op ch1 REG: OP_I changes 0x2 -> 0x7 at edge n -> OP_O shows 0x7 at edge n+1. In PASS the change is visible the same cycle.
- Two entries queued, ch0 mode switched 10->01 -> count cleared the next edge. Also: assert UserRSTn=0 mid-burst -> all counts 0 immediately (asynchronous), and the first post-reset write lands in slot 0.
